nas_vid_gen: RTL and testbench

Parametrised video timing and character-address generator, successor to `nas_vid`'s fixed NASCOM 2 timing chain. It produces composite sync, active-area qualifiers, a frame-buffer character address and the glyph scanline index from a single dot clock. It also adds two behaviours `nas_vid` lacks: run-time 50/60 Hz frame selection and a hardware row-rotation (scroll) offset. It sits between the dot clock and the video RAM/character-ROM pipeline.

---
 rtl/nas_vid_gen_if.sv | 29 ++
 rtl/nas_vid_gen.sv | 178 +++++++++++++++++
 tb/tb_nas_vid_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/nas_vid_gen_if.sv
// rtl/nas_vid_gen_if.sv - video timing generator port bundle
interface nas_vid_gen_if #(
  parameter int ADDR_W = 10,
  parameter int TOP_W  = 4,
  parameter int SCAN_W = 4
);
  logic              mode_60hz;
  logic [TOP_W-1:0]  top_row;
  logic              vid_sync;
  logic              active_h;
  logic              active_v;
  logic              active;
  logic [ADDR_W-1:0] char_addr;
  logic [SCAN_W-1:0] scanline;
  logic              line_start;
  logic              frame_start;

  modport master (
    input  mode_60hz, top_row,
    output vid_sync, active_h, active_v, active, char_addr, scanline,
           line_start, frame_start
  );

  modport slave (
    output mode_60hz, top_row,
    input  vid_sync, active_h, active_v, active, char_addr, scanline,
           line_start, frame_start
  );
endinterface

// File: rtl/nas_vid_gen.sv
// rtl/nas_vid_gen.sv - parametrised video timing and character-address generator
// Outputs are registered from the next counter state so they line up with it.
module nas_vid_gen #(
  parameter int DOTS_PER_CHAR  = 8,
  parameter int H_TOTAL        = 128,
  parameter int H_ACTIVE       = 48,
  parameter int H_SYNC_START   = 56,
  parameter int H_SYNC_LEN     = 9,
  parameter int ROWS           = 16,
  parameter int SCAN_PER_ROW   = 12,
  parameter int V_ACTIVE_START = 40,
  parameter int V_TOTAL_50     = 312,
  parameter int V_TOTAL_60     = 262,
  parameter int VS_START_50    = 276,
  parameter int VS_START_60    = 238,
  parameter int VS_LEN         = 3,
  parameter int ROW_STRIDE     = 64,
  parameter int ADDR_W         = 10
) (
  input  logic          clk,
  input  logic          reset,
  nas_vid_gen_if.master vid
);
  localparam int D_W       = (DOTS_PER_CHAR > 1) ? $clog2(DOTS_PER_CHAR) : 1;
  localparam int H_W       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_MAX     = (V_TOTAL_50 > V_TOTAL_60) ? V_TOTAL_50 : V_TOTAL_60;
  localparam int V_W       = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int T_W       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int S_W       = (SCAN_PER_ROW > 1) ? $clog2(SCAN_PER_ROW) : 1;
  localparam int V_ACT_END = V_ACTIVE_START + ROWS * SCAN_PER_ROW;

  localparam logic [D_W-1:0] D_LAST   = D_W'(DOTS_PER_CHAR - 1);
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [S_W-1:0] S_LAST   = S_W'(SCAN_PER_ROW - 1);
  localparam logic [V_W-1:0] V50_LAST = V_W'(V_TOTAL_50 - 1);
  localparam logic [V_W-1:0] V60_LAST = V_W'(V_TOTAL_60 - 1);

  logic              r_run;
  logic [D_W-1:0]    r_d;
  logic [H_W-1:0]    r_h;
  logic [V_W-1:0]    r_v;
  logic [S_W-1:0]    r_s;
  logic [T_W-1:0]    r_r;
  logic              r_mode;
  logic [T_W-1:0]    r_top;

  logic              r_vid_sync;
  logic              r_active_h;
  logic              r_active_v;
  logic              r_active;
  logic [ADDR_W-1:0] r_char_addr;
  logic [S_W-1:0]    r_scanline;
  logic              r_line_start;
  logic              r_frame_start;

  logic              w_latch;
  logic              w_mode;
  logic [T_W-1:0]    w_top;
  logic [T_W-1:0]    w_top_eff;
  logic              w_d_wrap;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_line_adv;
  logic [D_W-1:0]    w_d;
  logic [H_W-1:0]    w_h;
  logic [V_W-1:0]    w_v;
  logic [S_W-1:0]    w_s;
  logic [T_W-1:0]    w_r;
  logic              w_act_h;
  logic              w_act_v;
  logic              w_hsync;
  logic              w_vsync;
  logic [31:0]       w_vs_start;
  logic [31:0]       w_row_sum;
  logic [31:0]       w_mem_row;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_latch    = r_run && (r_d == '0) && (r_h == '0) && (r_v == '0);
    w_mode     = w_latch ? vid.mode_60hz : r_mode;
    w_top      = w_latch ? vid.top_row : r_top;
    w_d_wrap   = (r_d == D_LAST);
    w_h_wrap   = (r_h == H_LAST);
    w_v_wrap   = (r_v == (r_mode ? V60_LAST : V50_LAST));
    w_line_adv = w_d_wrap && w_h_wrap;

    w_d = '0;
    w_h = '0;
    w_v = '0;
    w_s = '0;
    w_r = '0;
    // Before the first running edge the state is pinned at (0,0,0).
    if (r_run) begin
      w_d = w_d_wrap ? '0 : r_d + D_W'(1);
      w_h = r_h;
      if (w_d_wrap) begin
        w_h = w_h_wrap ? '0 : r_h + H_W'(1);
      end
      w_v = r_v;
      w_s = r_s;
      w_r = r_r;
      if (w_line_adv) begin
        w_v = w_v_wrap ? '0 : r_v + V_W'(1);
        w_s = '0;
        w_r = '0;
        if ((32'(w_v) > V_ACTIVE_START) && (32'(w_v) < V_ACT_END)) begin
          if (r_s == S_LAST) begin
            w_r = r_r + T_W'(1);
          end else begin
            w_s = r_s + S_W'(1);
            w_r = r_r;
          end
        end
      end
    end

    w_act_h    = (32'(w_h) < H_ACTIVE);
    w_act_v    = (32'(w_v) >= V_ACTIVE_START) && (32'(w_v) < V_ACT_END);
    w_hsync    = (32'(w_h) >= H_SYNC_START) && (32'(w_h) < H_SYNC_START + H_SYNC_LEN);
    w_vs_start = w_mode ? 32'(VS_START_60) : 32'(VS_START_50);
    w_vsync    = (32'(w_v) >= w_vs_start) && (32'(w_v) < w_vs_start + VS_LEN);

    // Out-of-range scroll values fall back to no rotation.
    w_top_eff  = (32'(w_top) < ROWS) ? w_top : '0;
    w_row_sum  = 32'(w_r) + 32'(w_top_eff);
    w_mem_row  = (w_row_sum >= ROWS) ? (w_row_sum - ROWS) : w_row_sum;
    w_addr     = (w_act_h && w_act_v) ? ADDR_W'(w_mem_row * ROW_STRIDE + 32'(w_h)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run         <= 1'b0;
      r_d           <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_s           <= '0;
      r_r           <= '0;
      r_mode        <= 1'b0;
      r_top         <= '0;
      r_vid_sync    <= 1'b1;
      r_active_h    <= 1'b0;
      r_active_v    <= 1'b0;
      r_active      <= 1'b0;
      r_char_addr   <= '0;
      r_scanline    <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_d   <= w_d;
      r_h   <= w_h;
      r_v   <= w_v;
      r_s   <= w_s;
      r_r   <= w_r;
      if (w_latch) begin
        r_mode <= vid.mode_60hz;
        r_top  <= vid.top_row;
      end
      r_vid_sync    <= ~(w_hsync ^ w_vsync);
      r_active_h    <= w_act_h;
      r_active_v    <= w_act_v;
      r_active      <= w_act_h && w_act_v;
      r_char_addr   <= w_addr;
      r_scanline    <= w_act_v ? w_s : '0;
      r_line_start  <= (w_d == '0) && (w_h == '0);
      r_frame_start <= (w_d == '0) && (w_h == '0) && (w_v == '0);
    end
  end

  assign vid.vid_sync    = r_vid_sync;
  assign vid.active_h    = r_active_h;
  assign vid.active_v    = r_active_v;
  assign vid.active      = r_active;
  assign vid.char_addr   = r_char_addr;
  assign vid.scanline    = r_scanline;
  assign vid.line_start  = r_line_start;
  assign vid.frame_start = r_frame_start;
endmodule

// File: tb/tb_nas_vid_gen.sv
// tb/tb_nas_vid_gen.sv - bench for nas_vid_gen: reduced-geometry model check plus default-timing line check
module tb_nas_vid_gen;
  localparam int DPC  = 2;
  localparam int HT   = 16;
  localparam int HA   = 6;
  localparam int HSS  = 8;
  localparam int HSL  = 3;
  localparam int NR   = 4;
  localparam int SPR  = 3;
  localparam int VAS  = 3;
  localparam int VT50 = 22;
  localparam int VT60 = 18;
  localparam int VS50 = 18;
  localparam int VS60 = 15;
  localparam int VSL  = 2;
  localparam int STR  = 8;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_d;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   def_done = 1'b0;

  nas_vid_gen_if #(.ADDR_W(AW), .TOP_W(2), .SCAN_W(2)) s_if ();
  nas_vid_gen_if d_if ();

  nas_vid_gen #(
    .DOTS_PER_CHAR(DPC), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS),
    .H_SYNC_LEN(HSL), .ROWS(NR), .SCAN_PER_ROW(SPR), .V_ACTIVE_START(VAS),
    .V_TOTAL_50(VT50), .V_TOTAL_60(VT60), .VS_START_50(VS50), .VS_START_60(VS60),
    .VS_LEN(VSL), .ROW_STRIDE(STR), .ADDR_W(AW)
  ) u_dut_s (
    .clk   (clk),
    .reset (rst_s),
    .vid   (s_if.master)
  );

  nas_vid_gen u_dut_d (
    .clk   (clk),
    .reset (rst_d),
    .vid   (d_if.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: derives (d,h,v) from the cycle position inside the frame.
  initial begin
    int pos, m_top, d, hh, vv, lin, vss, top, flen, row, mem, addr, sc;
    bit rs, m_mode, ah, av, hs, vs;
    pos = 0;
    m_mode = 1'b0;
    m_top = 0;
    forever begin
      @(posedge clk);
      rs = rst_s;
      @(negedge clk);
      if (rs) begin
        check("rst_vid_sync", s_if.vid_sync, 1);
        check("rst_active_h", s_if.active_h, 0);
        check("rst_active_v", s_if.active_v, 0);
        check("rst_active", s_if.active, 0);
        check("rst_char_addr", s_if.char_addr, 0);
        check("rst_scanline", s_if.scanline, 0);
        check("rst_line_start", s_if.line_start, 0);
        check("rst_frame_start", s_if.frame_start, 0);
        pos = 0;
      end else begin
        if (pos == 0) begin
          m_mode = s_if.mode_60hz;
          m_top  = int'(s_if.top_row);
        end
        d    = pos % DPC;
        hh   = (pos / DPC) % HT;
        vv   = pos / (DPC * HT);
        ah   = (hh < HA);
        av   = (vv >= VAS) && (vv < VAS + NR * SPR);
        hs   = (hh >= HSS) && (hh < HSS + HSL);
        vss  = m_mode ? VS60 : VS50;
        vs   = (vv >= vss) && (vv < vss + VSL);
        lin  = vv - VAS;
        sc   = av ? (lin % SPR) : 0;
        row  = av ? (lin / SPR) : 0;
        top  = (m_top < NR) ? m_top : 0;
        mem  = (row + top) % NR;
        addr = (ah && av) ? ((mem * STR + hh) % (1 << AW)) : 0;
        check("vid_sync", s_if.vid_sync, !(hs ^ vs));
        check("active_h", s_if.active_h, ah);
        check("active_v", s_if.active_v, av);
        check("active", s_if.active, ah && av);
        check("char_addr", s_if.char_addr, addr);
        check("scanline", s_if.scanline, sc);
        check("line_start", s_if.line_start, (d == 0) && (hh == 0));
        check("frame_start", s_if.frame_start, pos == 0);
        flen = DPC * HT * (m_mode ? VT60 : VT50);
        pos++;
        if (pos == flen) pos = 0;
      end
    end
  end

  // Default geometry: first-line pulses, line period and sync/active widths.
  initial begin
    int ls_prev, nlow, nah, nls;
    rst_d = 1'b1;
    d_if.mode_60hz = 1'b0;
    d_if.top_row = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("def_rst_vid_sync", d_if.vid_sync, 1);
    check("def_rst_frame_start", d_if.frame_start, 0);
    check("def_rst_line_start", d_if.line_start, 0);
    check("def_rst_active_h", d_if.active_h, 0);
    @(posedge clk);
    #1 rst_d = 1'b0;
    @(posedge clk);
    ls_prev = -1;
    nlow = 0;
    nah = 0;
    nls = 0;
    for (int c = 0; c < 2050; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("def_first_frame_start", d_if.frame_start, 1);
        check("def_first_line_start", d_if.line_start, 1);
        check("def_first_active_h", d_if.active_h, 1);
        check("def_first_active_v", d_if.active_v, 0);
      end
      if (c == 1) begin
        check("def_fs_one_cycle", d_if.frame_start, 0);
        check("def_ls_one_cycle", d_if.line_start, 0);
      end
      if (d_if.line_start === 1'b1) begin
        if (ls_prev >= 0) check("def_line_period", c - ls_prev, 1024);
        ls_prev = c;
        nls++;
      end
      if (c < 1024) begin
        nlow += (d_if.vid_sync === 1'b0) ? 1 : 0;
        nah  += (d_if.active_h === 1'b1) ? 1 : 0;
      end
    end
    check("def_hsync_low", nlow, 72);
    check("def_active_h_width", nah, 384);
    check("def_line_count", nls, 3);
    def_done = 1'b1;
  end

  initial begin
    rst_s = 1'b1;
    s_if.mode_60hz = 1'b0;
    s_if.top_row = '0;
    repeat (3) @(posedge clk);
    #1 rst_s = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      @(posedge clk);
      #1;
      rst_s = (i == 2345) || ((i > 3000) && ($urandom_range(0, 1999) == 0));
      if (i == 800) s_if.mode_60hz = 1'b1;
      else if (i == 4000) s_if.mode_60hz = 1'b0;
      else if ($urandom_range(0, 299) == 0) s_if.mode_60hz = 1'($urandom_range(0, 1));
      if (i == 100) s_if.top_row = 2'd3;
      else if ($urandom_range(0, 99) == 0) s_if.top_row = 2'($urandom_range(0, 3));
    end
    check("def_done", def_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
